// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH, with
// bout = 1 when a < b + bin. One bit slice is evaluated per clock, LSB
// first, and a single borrow flop carries the borrow between slices.
//
// Handshake: start is sampled only in IDLE. On acceptance the operands and
// borrow-in are captured, busy is high for WIDTH cycles while the bits are
// processed, then done pulses for one cycle as diff/bout update. diff and
// bout hold their value until the next completed operation.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (clears control, operands, results)
//   start  operation request (ignored outside IDLE)
//   a, b   minuend / subtrahend, WIDTH bits, captured on acceptance
//   bin    borrow-in, captured on acceptance
//   busy   high while bit slices are being processed
//   done   one-cycle pulse, diff/bout valid and freshly updated
//   diff   registered difference
//   bout   registered borrow-out
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             d_bit;
  logic             br_next;

  // Single-bit full-subtractor slice.
  function automatic logic diff_bit(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  // Borrow out of a slice: y exceeds x, or they are equal and a borrow
  // is already pending from the lower slice.
  function automatic logic borrow_bit(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  assign d_bit   = diff_bit(sa[0], sb[0], br);
  assign br_next = borrow_bit(sa[0], sb[0], br);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          br <= br_next;
          sa <= sa >> 1;
          sb <= sb >> 1;
          // Result bits enter at the MSB so that after WIDTH shifts the
          // LSB-first stream lines up with bit 0.
          sd <= {d_bit, sd[WIDTH-1:1]};
          if (cnt == LAST) begin
            // Publish the final word including the slice computed this edge.
            diff  <= {d_bit, sd[WIDTH-1:1]};
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          // start is deliberately not looked at here; a request held high
          // is taken on the following edge from IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with a 1-cycle start pulse. Reports the number of
  // cycles busy was seen high and the edge count from accept to done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        input bit scramble, output int busy_cyc, output int lat);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    tick();                       // accept edge E0
    start = 1'b0;
    busy_cyc = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 30) begin
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      tick();
      lat++;
      if (busy) busy_cyc++;
      if (busy && done) check("busy_done_overlap", 1, 0);
    end
  endtask

  logic [W:0] ref_v;
  int         bc, lt, ndone;
  logic [W-1:0] ra, rb;
  logic         rbin;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    rst = 1'b0;
    tick();

    // 0x5A - 0x23 with timing checks
    run_op(8'h5A, 8'h23, 1'b0, 1'b0, bc, lt);
    check("t1_latency", lt, 8);
    check("t1_busy_cycles", bc, 8);
    check("t1_diff", diff, 8'h37);
    check("t1_bout", bout, 0);
    check("t1_busy_at_done", busy, 0);
    tick();
    check("t1_done_falls", done, 0);
    tick();
    check("t1_done_one_cycle", done, 0);
    check("t1_diff_hold", diff, 8'h37);

    run_op(8'h10, 8'h20, 1'b0, 1'b0, bc, lt);
    check("t2_diff", diff, 8'hF0);
    check("t2_bout", bout, 1);
    tick();

    run_op(8'h00, 8'h00, 1'b1, 1'b0, bc, lt);
    check("t3_diff", diff, 8'hFF);
    check("t3_bout", bout, 1);
    tick();

    // operands change while running: result must follow captured values
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, bc, lt);
    check("t4_latency", lt, 8);
    check("t4_diff", diff, 8'h00);
    check("t4_bout", bout, 0);
    tick();

    // start pulses during RUN (edges 2,5) and the DONE cycle (edge 9)
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'hAA; b = 8'h01; bin = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      start = (i == 2 || i == 5 || i == 9);
      tick();
      if (done) ndone++;
      if (i == 8) begin
        check("t5_done_e8", done, 1);
        check("t5_diff", diff, 8'h22);
        check("t5_bout", bout, 0);
      end
      if (i >= 9) check("t5_no_restart", busy, 0);
    end
    start = 1'b0;
    check("t5_done_count", ndone, 1);
    check("t5_diff_hold", diff, 8'h22);

    // asynchronous reset mid-run
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_diff", diff, 0);
    check("t6_rst_bout", bout, 0);
    #1 rst = 1'b0;
    tick();
    check("t6_idle_after_rst", busy, 0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0, bc, lt);
    check("t6_latency", lt, 8);
    check("t6_diff", diff, 8'h7F);
    check("t6_bout", bout, 0);
    tick();

    // back-to-back random operations, start held high
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      a = ra; b = rb; bin = rbin;
      ref_v = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      tick();                                  // accept edge
      check("rnd_accept", busy, 1);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      for (int j = 1; j < W; j++) tick();
      check("rnd_busy_last", busy, 1);
      tick();                                  // edge W
      check("rnd_done", done, 1);
      check("rnd_diff", diff, ref_v[W-1:0]);
      check("rnd_bout", bout, ref_v[W]);
      tick();                                  // DONE -> IDLE, start ignored
      check("rnd_gap", busy | done, 0);
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
